// File: rtl/if_mem_arbiter.sv
// Arbiter sharing one request/addr_ok/data_ok memory port between
// instruction fetch and data load/store. Responses return in order; a small
// tracking FIFO routes each response to its owner and swallows instruction
// responses orphaned by a pipeline flush.
module if_mem_arbiter #(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Tracking FIFO storage and pointers (extra MSB separates full from empty)
    owner_e          owner_q   [OUTSTANDING];
    logic            discard_q [OUTSTANDING];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [SW-1:0]   starve_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            inst_act;
    logic            inst_win;
    logic            data_win;
    logic            push;
    logic            pop;
    owner_e          head_owner;
    logic            head_discard;

    assign fifo_empty   = (wptr_q == rptr_q);
    assign fifo_full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign head_owner   = owner_q[rptr_q[AW-1:0]];
    assign head_discard = discard_q[rptr_q[AW-1:0]];

    // Grant, issue mux, handshakes and response routing
    always_comb begin
        inst_act     = 1'b0;
        inst_win     = 1'b0;
        data_win     = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = 4'b0000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        push         = 1'b0;
        pop          = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        // A flush masks fetch so no new fetch can slip in behind it
        inst_act = inst_req && !flush;
        inst_win = inst_act && (!data_req || (starve_q == SW'(STARVE_LIMIT)));
        data_win = data_req && !inst_win;

        if (inst_win) begin
            mem_addr = inst_addr;
        end else if (data_win) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wr ? data_wstrb : 4'b0000;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end

        // A full FIFO blocks issue even if the head pops this same cycle
        mem_req      = !reset && (inst_win || data_win) && !fifo_full;
        push         = mem_req && mem_addr_ok;
        inst_addr_ok = push && inst_win;
        data_addr_ok = push && data_win;

        pop = !reset && mem_data_ok && !fifo_empty;
        if (pop) begin
            if (head_owner == OWN_DATA) begin
                data_data_ok = 1'b1;
            end else begin
                inst_data_ok = !head_discard && !flush;
            end
        end
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // FIFO pointers and entries; flush marks every inst entry as discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                owner_q[i]   <= OWN_INST;
                discard_q[i] <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                    if (owner_q[i] == OWN_INST) begin
                        discard_q[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                owner_q[wptr_q[AW-1:0]]   <= inst_win ? OWN_INST : OWN_DATA;
                discard_q[wptr_q[AW-1:0]] <= 1'b0;
                wptr_q                    <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    // Starvation counter: counts cycles a live fetch loses to an accepted data request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (inst_req && !flush && data_addr_ok) begin
            if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + SW'(1);
            end
        end else if (inst_addr_ok || !inst_req) begin
            starve_q <= '0;
        end
    end

endmodule

// File: tb/tb_if_mem_arbiter.sv
// Directed bench for if_mem_arbiter: a cycle table covering streaming,
// starvation, FIFO-full and flush behaviour, plus hand sequences for a
// store and a mid-operation reset.
module tb_if_mem_arbiter;

    localparam logic [31:0] IADDR = 32'h1c00_0000;
    localparam logic [31:0] DADDR = 32'h0000_1000;
    localparam logic [1:0]  WN = 2'd0;
    localparam logic [1:0]  WI = 2'd1;
    localparam logic [1:0]  WD = 2'd2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int errors;
    int checks;

    if_mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ireq;
        logic        dreq;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        ex_mreq;
        logic [1:0]  win;
        logic        ex_iaok;
        logic        ex_daok;
        logic        ex_idok;
        logic        ex_ddok;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ireq, input logic dreq, input logic fl,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic mreq, input logic [1:0] win,
                                input logic iaok, input logic daok,
                                input logic idok, input logic ddok);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.fl = fl; v.aok = aok; v.dok = dok; v.rd = rd;
        v.ex_mreq = mreq; v.win = win; v.ex_iaok = iaok; v.ex_daok = daok;
        v.ex_idok = idok; v.ex_ddok = ddok;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        data_wstrb = 4'hf; inst_addr = IADDR; data_addr = DADDR;
        data_wdata = 32'h1234_5678; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic chk_hs(input string tag, input logic mr, input logic iaok, input logic daok,
                          input logic idok, input logic ddok);
        chk({tag, ".mem_req"},      32'(mem_req),      32'(mr));
        chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(iaok));
        chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(daok));
        chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(idok));
        chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(ddok));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        reset = 1'b1;

        // Cycle table: each row is inputs for one cycle plus expected outputs
        // streaming inst-only, response one cycle later
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(1,0,0,1,1,32'ha000_0000,1,WI,1,0,1,0));
        vt.push_back(mk(1,0,0,1,1,32'ha000_0001,1,WI,1,0,1,0));
        vt.push_back(mk(0,0,0,1,1,32'ha000_0002,0,WN,0,0,1,0));
        vt.push_back(mk(0,0,0,1,1,32'ha000_0003,0,WN,0,0,0,0)); // response with empty FIFO
        // both requesting: data wins 4 times, then inst is forced through
        vt.push_back(mk(1,1,0,1,0,32'h0,        1,WD,0,1,0,0));
        vt.push_back(mk(1,1,0,1,1,32'hb000_0000,1,WD,0,1,0,1));
        vt.push_back(mk(1,1,0,1,1,32'hb000_0001,1,WD,0,1,0,1));
        vt.push_back(mk(1,1,0,1,1,32'hb000_0002,1,WD,0,1,0,1));
        vt.push_back(mk(1,1,0,1,1,32'hb000_0003,1,WI,1,0,0,1));
        vt.push_back(mk(1,1,0,1,1,32'hb000_0004,1,WD,0,1,1,0)); // counter restarted
        vt.push_back(mk(0,0,0,1,1,32'hb000_0005,0,WN,0,0,0,1));
        // fill FIFO, stall while full even with a pop, then resume
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(0,1,0,1,0,32'h0,        1,WD,0,1,0,0));
        vt.push_back(mk(0,1,0,1,1,32'hc000_0000,0,WD,0,0,1,0));
        vt.push_back(mk(0,1,0,1,0,32'h0,        1,WD,0,1,0,0));
        vt.push_back(mk(0,0,0,1,1,32'hc000_0001,0,WN,0,0,0,1));
        vt.push_back(mk(0,0,0,1,1,32'hc000_0002,0,WN,0,0,0,1));
        // memory not accepting
        vt.push_back(mk(1,0,0,0,0,32'h0,        1,WI,0,0,0,0));
        // inst A + data B outstanding, flush, then two responses
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(0,1,0,1,0,32'h0,        1,WD,0,1,0,0));
        vt.push_back(mk(1,0,1,1,0,32'h0,        0,WN,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h1111_1111,0,WN,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h2222_2222,0,WN,0,0,0,1));
        // flush popping an inst head while data is pushed, inst masked
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(1,1,1,1,1,32'h3333_3333,1,WD,0,1,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h4444_4444,0,WN,0,0,0,1));
        // flush discards the head and the entry behind it; a later fetch is clean
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(0,0,1,1,1,32'h5555_5555,0,WN,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h6666_6666,0,WN,0,0,0,0));
        vt.push_back(mk(1,0,0,1,0,32'h0,        1,WI,1,0,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h7777_7777,0,WN,0,0,1,0));
        // flush with empty FIFO masks a lone fetch
        vt.push_back(mk(1,0,1,1,0,32'h0,        0,WN,0,0,0,0));

        // Reset state
        #2;
        mem_data_ok = 1'b1;
        chk_hs("reset", 0, 0, 0, 0, 0);
        mem_data_ok = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < vt.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            inst_req = vt[i].ireq; data_req = vt[i].dreq; flush = vt[i].fl;
            mem_addr_ok = vt[i].aok; mem_data_ok = vt[i].dok; mem_rdata = vt[i].rd;
            #4;
            chk_hs(tag, vt[i].ex_mreq, vt[i].ex_iaok, vt[i].ex_daok, vt[i].ex_idok, vt[i].ex_ddok);
            if (vt[i].ex_mreq) begin
                chk({tag, ".mem_addr"}, mem_addr, (vt[i].win == WI) ? IADDR : DADDR);
                chk({tag, ".mem_wr"}, 32'(mem_wr), 32'h0);
                chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'h0);
                if (vt[i].win == WI) chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
            end
            if (vt[i].ex_idok) chk({tag, ".inst_rdata"}, inst_rdata, vt[i].rd);
            if (vt[i].ex_ddok) chk({tag, ".data_rdata"}, data_rdata, vt[i].rd);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Store issue and acknowledgement
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h1c00_0100; data_wdata = 32'hdead_beef; mem_addr_ok = 1'b1;
        #4;
        chk_hs("store", 1, 0, 1, 0, 0);
        chk("store.mem_wr", 32'(mem_wr), 32'h1);
        chk("store.mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("store.mem_addr", mem_addr, 32'h1c00_0100);
        chk("store.mem_wdata", mem_wdata, 32'hdead_beef);
        next_cycle();
        idle_inputs();
        mem_data_ok = 1'b1;
        #4;
        chk_hs("store_ack", 0, 0, 0, 0, 1);
        next_cycle();
        idle_inputs();

        // Reset with two outstanding, stale responses afterwards are ignored
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        #4;
        chk_hs("rst_pre0", 1, 1, 0, 0, 0);
        next_cycle();
        inst_req = 1'b0; data_req = 1'b1;
        #4;
        chk_hs("rst_pre1", 1, 0, 1, 0, 0);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        mem_data_ok = 1'b1;
        #4;
        chk_hs("rst_mid", 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h9999_0000;
        #4;
        chk_hs("rst_stale0", 0, 0, 0, 0, 0);
        next_cycle();
        #4;
        chk_hs("rst_stale1", 0, 0, 0, 0, 0);
        next_cycle();
        idle_inputs();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        #4;
        chk_hs("rst_issue", 1, 1, 0, 0, 0);
        chk("rst_issue.mem_addr", mem_addr, IADDR);
        next_cycle();
        inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hface_cafe;
        #4;
        chk_hs("rst_resp", 0, 0, 0, 1, 0);
        chk("rst_resp.inst_rdata", inst_rdata, 32'hface_cafe);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_mem_arbiter.md
Name: if_mem_arbiter

Overview:
- Shares one single-port memory interface between the instruction-fetch requester and the data (load/store) requester.
- Memory protocol: request/addr_ok/data_ok handshake.
- Responses return in order. The block tracks outstanding transactions so each response is routed back to its owner.
- On an ertn/exception flush, in-flight instruction responses are discarded.

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered transactions (FIFO depth, power of 2, >=2)
- STARVE_LIMIT, 4, consecutive cycles inst may lose arbitration before it is forced to win

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush (ertn/exception); pulse
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1=store
- data_wstrb  in  4  byte enables
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data / store acknowledgement
- data_rdata  out  32  load data
- mem_req  out  1  memory request
- mem_wr  out  1  memory write
- mem_wstrb  out  4  memory byte enables (0 for reads)
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory response data

Behaviour:
- Reset (async): tracking FIFO empty, starve_cnt=0. All outputs derive from inputs and state, so all handshake outputs are 0 while reset is asserted or no request is present.
- Grant (combinational):
  - Only one requester active: it wins.
  - Both active: data wins, unless starve_cnt==STARVE_LIMIT, in which case inst wins.
  - inst_req is ignored in any cycle where flush=1.
- Issue: mem_req = (granted requester exists) && !fifo_full.
  - mem_* fields mux from the winner. An inst winner drives mem_wr=0, mem_wstrb=0, mem_wdata=0.
  - A full FIFO blocks issue even if a pop happens in the same cycle.
- Accept: winner's addr_ok = mem_req && mem_addr_ok; the loser's addr_ok=0. Acceptance is zero-latency (same cycle as mem_addr_ok).
  - On accept, push {owner, discard=0} into the FIFO.
- Response: on mem_data_ok with FIFO non-empty, pop the head.
  - owner=data: data_data_ok=1.
  - owner=inst and discard=0: inst_data_ok=1.
  - owner=inst and discard=1: response swallowed; inst_data_ok=0.
  - inst_rdata and data_rdata pass mem_rdata straight through; they are valid only when the respective data_ok is asserted.
- mem_data_ok with FIFO empty: ignored, no state change, no outputs.
- Simultaneous push and pop: both occur; the count is unchanged.
- Flush: sets discard on every inst entry present in the FIFO that cycle, including the head being popped that same cycle.
  - An inst response arriving in a flush cycle is suppressed.
  - Data entries are unaffected.
  - A push in the flush cycle can only be data, because inst is masked.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when inst_req && !flush && data accepted.
  - Clears when inst is accepted or inst_req=0.
  - Otherwise holds (including a stall because the FIFO is full).
- Reset mid-operation clears the FIFO. Stale responses that arrive afterward hit an empty FIFO and are ignored.
- FIFO pointers wrap modulo OUTSTANDING; full/empty are distinguished with an extra pointer bit.

Test Plan:
- Inst-only stream, mem_addr_ok=1, mem_data_ok 1 cycle later -> back-to-back inst_addr_ok every cycle; inst_data_ok each response; inst_rdata==mem_rdata; data_data_ok never 1.
- Both requests every cycle, STARVE_LIMIT=4 -> data accepted on 4 consecutive cycles, inst on cycle 5, then starve_cnt=0.
- Issue 2 accepts with mem_data_ok held 0 (OUTSTANDING=2) -> mem_req=0 on 3rd cycle; after one mem_data_ok, issue resumes the next cycle; responses routed in issue order.
- Inst A and data B outstanding, flush pulse, then 2 responses 0x11111111, 0x22222222 -> inst_data_ok stays 0, data_data_ok=1 with data_rdata=0x22222222.
- Store data_wr=1, wstrb=4'b0011, addr=0x1c000100, wdata=0xdeadbeef -> mem_wr=1, mem_wstrb=0011, mem_addr/wdata match, data_data_ok on response.
- Reset asserted with 2 outstanding, released, then mem_data_ok -> no data_ok outputs, FIFO empty, next request issues normally.
